// File: rtl/control_seq_pkg.sv
// Shared types for the registered control sequencer: opcode/func encodings,
// select codes, FSM states, exception causes and the control bundle.
package control_seq_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FUNC_W   = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned CAUSE_W  = 2;
  localparam int unsigned MC_CNT_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ARITHM = 4'h0,
    OP_LW     = 4'h1,
    OP_SW     = 4'h2,
    OP_BLT    = 4'h3,
    OP_BGT    = 4'h4,
    OP_BE     = 4'h5,
    OP_JMP    = 4'h6,
    OP_HALT   = 4'h7
  } opcode_t;

  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_NOT = 4'h5,
    ALU_ROR = 4'h6,
    ALU_ROL = 4'h7,
    ALU_SHL = 4'h8,
    ALU_SHR = 4'h9,
    ALU_MUL = 4'hA,
    ALU_DIV = 4'hB
  } control_e;

  typedef enum logic [SEL_W-1:0] {
    SEL_NONE      = 2'b00,
    SEL_FOURBIT   = 2'b01,
    SEL_EIGHTBIT  = 2'b10,
    SEL_TWELVEBIT = 2'b11
  } sel_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_MC = 2'd1,
    HALTED  = 2'd2,
    EXC     = 2'd3
  } ctrl_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    EXC_NONE = 2'b00,
    EXC_DIV0 = 2'b01,
    EXC_OVF  = 2'b10,
    EXC_ILL  = 2'b11
  } exc_cause_e;

  typedef struct packed {
    logic alu_op;
    sel_t offset_sel;
    logic mem2r;
    logic memwr;
    logic reg_wr;
    logic r0_read;
    logic se_imm_a;
  } ctrl_bundle_t;

  // MUL and DIV occupy the ALU for several cycles
  function automatic logic is_multicycle(input control_e f);
    return (f == ALU_MUL) || (f == ALU_DIV);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode/func to control-bundle map with illegal flag.
module control_decode
  import control_seq_pkg::*;
(
  input  opcode_t      opcode,
  input  control_e     func,
  output ctrl_bundle_t bundle_c,
  output logic         illegal_c,
  output logic         multicycle_c
);

  // Decode table; unknown opcodes raise illegal with an empty bundle
  always_comb begin
    bundle_c     = '0;
    illegal_c    = 1'b0;
    multicycle_c = 1'b0;
    case (opcode)
      OP_ARITHM: begin
        bundle_c.reg_wr = 1'b1;
        if ((func == ALU_ROR) || (func == ALU_ROL) ||
            (func == ALU_SHL) || (func == ALU_SHR)) begin
          bundle_c.offset_sel = SEL_FOURBIT;
        end
        multicycle_c = is_multicycle(func);
      end
      OP_LW: begin
        bundle_c.alu_op     = 1'b1;
        bundle_c.mem2r      = 1'b1;
        bundle_c.reg_wr     = 1'b1;
        bundle_c.offset_sel = SEL_EIGHTBIT;
      end
      OP_SW: begin
        bundle_c.alu_op     = 1'b1;
        bundle_c.memwr      = 1'b1;
        bundle_c.offset_sel = SEL_EIGHTBIT;
      end
      OP_BLT, OP_BGT, OP_BE: begin
        bundle_c.r0_read    = 1'b1;
        bundle_c.se_imm_a   = 1'b1;
        bundle_c.offset_sel = SEL_EIGHTBIT;
      end
      OP_JMP: begin
        bundle_c.se_imm_a   = 1'b1;
        bundle_c.offset_sel = SEL_TWELVEBIT;
      end
      OP_HALT: begin
        bundle_c = '0;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_seq.sv
// Registered multi-cycle control sequencer: decode, MC hold, exception latch,
// sticky halt and retired-instruction counter.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int unsigned OPCODE_W   = 4,
  parameter int unsigned FUNC_W     = 4,
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  input  logic                stall,
  input  logic                div0,
  input  logic                overflow,
  input  logic                exc_ack,
  output logic                ctrl_valid,
  output logic                alu_op,
  output logic [1:0]          offset_sel,
  output logic                mem2r,
  output logic                memwr,
  output logic                reg_wr,
  output logic                r0_read,
  output logic                se_imm_a,
  output logic                pc_hold,
  output logic                halt_sys,
  output logic                exc_valid,
  output logic [1:0]          exc_cause,
  output logic [CNT_W-1:0]    retired
);

  ctrl_bundle_t        dec_bundle;
  logic                dec_illegal;
  logic                dec_multicycle;

  ctrl_state_e         state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  ctrl_bundle_t        mc_bundle_q, mc_bundle_d;
  ctrl_bundle_t        bundle_q, bundle_d;
  logic                valid_q, valid_d;
  logic                pc_hold_q, pc_hold_d;
  logic                halt_q, halt_d;
  logic                exc_valid_q, exc_valid_d;
  exc_cause_e          cause_q, cause_d;
  logic [CNT_W-1:0]    retired_q, retired_d;

  logic                flag_exc;
  logic                accept_try;
  exc_cause_e          flag_cause;

  control_decode u_decode (
    .opcode       (opcode_t'(opcode)),
    .func         (control_e'(func)),
    .bundle_c     (dec_bundle),
    .illegal_c    (dec_illegal),
    .multicycle_c (dec_multicycle)
  );

  // ALU flags outrank an illegal opcode; DIV0 outranks OVF
  always_comb begin
    flag_exc   = div0 | overflow;
    accept_try = instr_valid & ~stall;
    if (div0) begin
      flag_cause = EXC_DIV0;
    end else if (overflow) begin
      flag_cause = EXC_OVF;
    end else begin
      flag_cause = EXC_ILL;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mc_bundle_d = mc_bundle_q;
    bundle_d    = '0;
    valid_d     = 1'b0;
    halt_d      = halt_q;
    exc_valid_d = exc_valid_q;
    cause_d     = cause_q;

    case (state_q)
      RUN: begin
        if (flag_exc || (accept_try && dec_illegal)) begin
          state_d     = EXC;
          exc_valid_d = 1'b1;
          cause_d     = flag_cause;
          halt_d      = 1'b1;
        end else if (accept_try) begin
          if (dec_multicycle) begin
            state_d     = WAIT_MC;
            cnt_d       = MC_CNT_W'(MC_LATENCY - 1);
            mc_bundle_d = dec_bundle;
          end else begin
            valid_d  = 1'b1;
            bundle_d = dec_bundle;
            if (opcode_t'(opcode) == OP_HALT) begin
              state_d = HALTED;
              halt_d  = 1'b1;
            end
          end
        end
      end
      WAIT_MC: begin
        if (flag_exc) begin
          state_d     = EXC;
          exc_valid_d = 1'b1;
          cause_d     = flag_cause;
          halt_d      = 1'b1;
          cnt_d       = '0;
        end else if (!stall) begin
          if (cnt_q == MC_CNT_W'(1)) begin
            state_d  = RUN;
            cnt_d    = '0;
            valid_d  = 1'b1;
            bundle_d = mc_bundle_q;
          end else begin
            cnt_d = cnt_q - MC_CNT_W'(1);
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      EXC: begin
        if (exc_ack) begin
          state_d     = RUN;
          exc_valid_d = 1'b0;
          cause_d     = EXC_NONE;
          halt_d      = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    pc_hold_d = (state_d != RUN) | stall;
    retired_d = retired_q + CNT_W'(valid_d);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      mc_bundle_q <= '0;
      bundle_q    <= '0;
      valid_q     <= 1'b0;
      pc_hold_q   <= 1'b0;
      halt_q      <= 1'b0;
      exc_valid_q <= 1'b0;
      cause_q     <= EXC_NONE;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mc_bundle_q <= mc_bundle_d;
      bundle_q    <= bundle_d;
      valid_q     <= valid_d;
      pc_hold_q   <= pc_hold_d;
      halt_q      <= halt_d;
      exc_valid_q <= exc_valid_d;
      cause_q     <= cause_d;
      retired_q   <= retired_d;
    end
  end

  assign ctrl_valid = valid_q;
  assign alu_op     = bundle_q.alu_op;
  assign offset_sel = bundle_q.offset_sel;
  assign mem2r      = bundle_q.mem2r;
  assign memwr      = bundle_q.memwr;
  assign reg_wr     = bundle_q.reg_wr;
  assign r0_read    = bundle_q.r0_read;
  assign se_imm_a   = bundle_q.se_imm_a;
  assign pc_hold    = pc_hold_q;
  assign halt_sys   = halt_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: expected bundles are queued at drive time
// and popped when ctrl_valid appears.
module tb_control_seq;
  import control_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic [3:0] opcode;
  logic [3:0] func;
  logic       stall;
  logic       div0;
  logic       overflow;
  logic       exc_ack;
  logic       ctrl_valid;
  logic       alu_op;
  logic [1:0] offset_sel;
  logic       mem2r;
  logic       memwr;
  logic       reg_wr;
  logic       r0_read;
  logic       se_imm_a;
  logic       pc_hold;
  logic       halt_sys;
  logic       exc_valid;
  logic [1:0] exc_cause;
  logic [3:0] retired;

  int         checks;
  int         failures;
  logic [7:0] exp_q[$];
  logic [3:0] exp_ret;

  control_seq #(
    .OPCODE_W   (4),
    .FUNC_W     (4),
    .MC_LATENCY (4),
    .CNT_W      (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .func        (func),
    .stall       (stall),
    .div0        (div0),
    .overflow    (overflow),
    .exc_ack     (exc_ack),
    .ctrl_valid  (ctrl_valid),
    .alu_op      (alu_op),
    .offset_sel  (offset_sel),
    .mem2r       (mem2r),
    .memwr       (memwr),
    .reg_wr      (reg_wr),
    .r0_read     (r0_read),
    .se_imm_a    (se_imm_a),
    .pc_hold     (pc_hold),
    .halt_sys    (halt_sys),
    .exc_valid   (exc_valid),
    .exc_cause   (exc_cause),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Bench reference: {alu_op, offset_sel[1:0], mem2r, memwr, reg_wr, r0_read, se_imm_a}
  function automatic logic [7:0] ref_ctrl(input logic [3:0] op, input logic [3:0] fn);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      4'h0: r = (fn >= 4'h6 && fn <= 4'h9) ? 8'b0_01_00100 : 8'b0_00_00100;
      4'h1: r = 8'b1_10_10100;
      4'h2: r = 8'b1_10_01000;
      4'h3, 4'h4, 4'h5: r = 8'b0_10_00011;
      4'h6: r = 8'b0_11_00001;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] got_ctrl();
    return {alu_op, offset_sel, mem2r, memwr, reg_wr, r0_read, se_imm_a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] fn, input logic expect_retire);
    instr_valid = 1'b1;
    opcode      = op;
    func        = fn;
    if (expect_retire) begin
      exp_q.push_back(ref_ctrl(op, fn));
      exp_ret = exp_ret + 4'd1;
    end
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    opcode      = 4'h0;
    func        = 4'h0;
  endtask

  task automatic test_reset(input string tag);
    idle();
    stall = 1'b0; div0 = 1'b0; overflow = 1'b0; exc_ack = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ctrl_valid, pc_hold, halt_sys, exc_valid, exc_cause, got_ctrl()} !== 14'h0) begin
      failures++;
      $display("FAIL reset_%s outputs got=%h want=0", tag,
               {ctrl_valid, pc_hold, halt_sys, exc_valid, exc_cause, got_ctrl()});
    end
    checks++;
    if (retired !== 4'd0) begin
      failures++;
      $display("FAIL reset_%s retired got=%0d want=0", tag, retired);
    end
    exp_q.delete();
    exp_ret = 4'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lw_sw_jmp();
    logic [3:0] ops[3];
    logic [7:0] e;
    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_JMP;
    for (int k = 0; k < 3; k++) begin
      drive(ops[k], 4'h0, 1'b1);
      tick();
      checks++;
      if (ctrl_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL lw_sw_jmp_valid[%0d] got=%b want=1", k, ctrl_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (got_ctrl() !== e) begin
          failures++;
          $display("FAIL lw_sw_jmp_bundle[%0d] got=%b want=%b", k, got_ctrl(), e);
        end
      end
    end
    idle();
    tick();
    checks++;
    if (ctrl_valid !== 1'b0 || got_ctrl() !== 8'h00 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL bubble got valid=%b bundle=%b hold=%b want 0", ctrl_valid, got_ctrl(), pc_hold);
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL lw_sw_jmp_retired got=%0d want=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_div_mc();
    logic [7:0] e;
    drive(OP_ARITHM, ALU_DIV, 1'b1);
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      checks++;
      if (ctrl_valid !== (c == 4) || pc_hold !== (c < 4) || (c < 4 && got_ctrl() !== 8'h00)) begin
        failures++;
        $display("FAIL div_cycle%0d got valid=%b hold=%b bundle=%b want valid=%b hold=%b",
                 c, ctrl_valid, pc_hold, got_ctrl(), c == 4, c < 4);
      end
      if (c == 4 && ctrl_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_ctrl() !== e) begin
          failures++;
          $display("FAIL div_bundle got=%b want=%b", got_ctrl(), e);
        end
      end
    end
    drive(OP_ARITHM, ALU_DIV, 1'b1);
    tick();
    idle();
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      checks++;
      if (ctrl_valid !== (c == 6) || pc_hold !== (c < 6)) begin
        failures++;
        $display("FAIL div_stall_cycle%0d got valid=%b hold=%b want valid=%b hold=%b",
                 c, ctrl_valid, pc_hold, c == 6, c < 6);
      end
      if (c == 6 && ctrl_valid === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_ctrl() !== e) begin
          failures++;
          $display("FAIL div_stall_bundle got=%b want=%b", got_ctrl(), e);
        end
      end
      if (c == 2) stall = 1'b1;
      if (c == 4) stall = 1'b0;
    end
    tick();
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL div_retired got=%0d want=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_ovf_in_mc();
    drive(OP_ARITHM, ALU_MUL, 1'b0);
    tick();
    idle();
    overflow = 1'b1;
    tick();
    overflow = 1'b0;
    checks++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b10 || halt_sys !== 1'b1 || ctrl_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_mc got exc=%b cause=%b halt=%b valid=%b want 1 10 1 0",
               exc_valid, exc_cause, halt_sys, ctrl_valid);
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL ovf_mc_retired got=%0d want=%0d", retired, exp_ret);
    end
    div0 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (ctrl_valid !== 1'b0 || exc_cause !== 2'b10 || exc_valid !== 1'b1) begin
        failures++;
        $display("FAIL exc_hold%0d got valid=%b cause=%b exc=%b want 0 10 1",
                 c, ctrl_valid, exc_cause, exc_valid);
      end
    end
    div0 = 1'b0;
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    checks++;
    if (exc_valid !== 1'b0 || exc_cause !== 2'b00 || halt_sys !== 1'b0 || pc_hold !== 1'b0) begin
      failures++;
      $display("FAIL ovf_ack got exc=%b cause=%b halt=%b hold=%b want 0 00 0 0",
               exc_valid, exc_cause, halt_sys, pc_hold);
    end
  endtask

  task automatic test_div0_ovf_add();
    logic [7:0] e;
    drive(OP_ARITHM, ALU_ADD, 1'b0);
    div0 = 1'b1;
    overflow = 1'b1;
    tick();
    idle();
    div0 = 1'b0;
    overflow = 1'b0;
    checks++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b01 || ctrl_valid !== 1'b0 || retired !== exp_ret) begin
      failures++;
      $display("FAIL div0_ovf got exc=%b cause=%b valid=%b ret=%0d want 1 01 0 %0d",
               exc_valid, exc_cause, ctrl_valid, retired, exp_ret);
    end
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    drive(OP_ARITHM, ALU_ADD, 1'b1);
    tick();
    idle();
    checks++;
    if (ctrl_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL add_after_ack valid got=%b want=1", ctrl_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (got_ctrl() !== e) begin
        failures++;
        $display("FAIL add_after_ack bundle got=%b want=%b", got_ctrl(), e);
      end
    end
    tick();
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL add_retired got=%0d want=%0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal_halt();
    logic [7:0] e;
    drive(4'hC, 4'h0, 1'b0);
    tick();
    idle();
    checks++;
    if (exc_valid !== 1'b1 || exc_cause !== 2'b11 || halt_sys !== 1'b1) begin
      failures++;
      $display("FAIL illegal got exc=%b cause=%b halt=%b want 1 11 1", exc_valid, exc_cause, halt_sys);
    end
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    drive(OP_HALT, 4'h0, 1'b1);
    tick();
    idle();
    checks++;
    if (ctrl_valid !== 1'b1 || exp_q.size() == 0) begin
      failures++;
      $display("FAIL halt_pulse got=%b want=1", ctrl_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (got_ctrl() !== e) begin
        failures++;
        $display("FAIL halt_bundle got=%b want=%b", got_ctrl(), e);
      end
    end
    div0 = 1'b1;
    drive(OP_LW, 4'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ctrl_valid !== 1'b0 || halt_sys !== 1'b1 || exc_valid !== 1'b0 || exc_cause !== 2'b00) begin
        failures++;
        $display("FAIL halted%0d got valid=%b halt=%b exc=%b cause=%b want 0 1 0 00",
                 c, ctrl_valid, halt_sys, exc_valid, exc_cause);
      end
    end
    checks++;
    if (retired !== exp_ret) begin
      failures++;
      $display("FAIL halt_retired got=%0d want=%0d", retired, exp_ret);
    end
    div0 = 1'b0;
    idle();
    test_reset("after_halt");
  endtask

  task automatic test_reset_mid_mc();
    drive(OP_ARITHM, ALU_MUL, 1'b0);
    tick();
    idle();
    tick();
    test_reset("mid_mc");
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (ctrl_valid !== 1'b0 || pc_hold !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_mc%0d got valid=%b hold=%b want 0 0", c, ctrl_valid, pc_hold);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] e;
    for (int i = 0; i < 17; i++) begin
      drive(OP_ARITHM, 4'(i % 10), 1'b1);
      tick();
      checks++;
      if (ctrl_valid !== 1'b1 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL b2b_valid[%0d] got=%b want=1", i, ctrl_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (got_ctrl() !== e) begin
          failures++;
          $display("FAIL b2b_bundle[%0d] got=%b want=%b", i, got_ctrl(), e);
        end
      end
    end
    idle();
    tick();
    checks++;
    if (retired !== exp_ret || exp_ret !== 4'd1) begin
      failures++;
      $display("FAIL wrap_retired got=%0d want=%0d", retired, exp_ret);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    exp_ret     = 4'd0;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 4'h0;
    func        = 4'h0;
    stall       = 1'b0;
    div0        = 1'b0;
    overflow    = 1'b0;
    exc_ack     = 1'b0;
    tick();
    test_reset("initial");
    test_lw_sw_jmp();
    test_div_mc();
    test_ovf_in_mc();
    test_div0_ovf_add();
    test_illegal_halt();
    test_reset_mid_mc();
    test_back_to_back_wrap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Registered, multi-cycle successor to the combinational main decoder.
- Decodes opcode/func into the datapath control bundle and holds the PC during multi-cycle ALU operations (MUL/DIV).
- Latches exceptions (div0, overflow, illegal opcode) with a cause code, keeps HALT sticky, and counts retired instructions.
- Sits between fetch/IF-ID and the ALU/memory stage.

Parameters:
- OPCODE_W, 4, opcode field width.
- FUNC_W, 4, ALU func field width.
- MC_LATENCY, 4, total cycles for MUL/DIV from accept to ctrl_valid. Legal range is 2 to 15.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  opcode/func are valid this cycle.
- opcode  in  OPCODE_W  types_pkg::opcode_t.
- func  in  FUNC_W  alu_pkg::control_e.
- stall  in  1  downstream stall; the block accepts nothing.
- div0  in  1  ALU divide-by-zero flag.
- overflow  in  1  ALU overflow flag.
- exc_ack  in  1  handler acknowledge; clears the exception.
- ctrl_valid  out  1  control bundle is valid this cycle.
- alu_op  out  1  1 = address add (LW/SW).
- offset_sel  out  2  types_pkg::sel_t: NONE/FOURBIT/EIGHTBIT/TWELVEBIT.
- mem2r, memwr, reg_wr, r0_read, se_imm_a  out  1 each  same meaning as the main decoder.
- pc_hold  out  1  freeze the PC/IF-ID register.
- halt_sys  out  1  system halted (HALT opcode or exception).
- exc_valid  out  1  exception pending.
- exc_cause  out  2  01 DIV0, 10 OVF, 11 ILLEGAL, 00 none.
- retired  out  CNT_W  count of ctrl_valid pulses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release):
  - State RUN.
  - All outputs 0, offset_sel=NONE, retired=0, MC counter=0.
- States: RUN, WAIT_MC, HALTED, EXC.
- Accept: state==RUN && instr_valid && !stall && !div0 && !overflow.
- Decode table (combinational, registered on accept):
  - ARITHM: reg_wr=1. offset_sel=FOURBIT for ROR/ROL/SHL/SHR, else NONE.
  - LW: alu_op, mem2r, reg_wr; EIGHTBIT.
  - SW: alu_op, memwr; EIGHTBIT.
  - BLT/BGT/BE: r0_read, se_imm_a; EIGHTBIT.
  - JMP: se_imm_a; TWELVEBIT.
  - HALT: no strobes.
- Single-cycle op: on accept, the bundle is registered and ctrl_valid=1 for exactly the next cycle. Latency is 1.
- MUL/DIV in ARITHM: on accept, go to WAIT_MC and load counter=MC_LATENCY-1.
  - While in WAIT_MC: pc_hold=1, ctrl_valid=0, all strobes 0.
  - The counter decrements each cycle that stall is 0 and freezes while stall is 1.
  - At counter==1: next cycle ctrl_valid=1 with the full bundle, state returns to RUN.
- Cycle with no accept in RUN: bubble. ctrl_valid=0, all strobes 0, offset_sel=NONE.
- pc_hold=1 whenever state is not RUN, or when stall=1.
- HALT opcode accepted: ctrl_valid pulses once with no strobes, then state becomes HALTED.
  - halt_sys=1 and sticky until rst_n.
  - All inputs are ignored, including div0/overflow.
- Exceptions:
  - Triggers: div0 or overflow in RUN or WAIT_MC, or instr_valid with an undefined opcode in RUN when not stalled.
  - Next cycle: state EXC, exc_valid=1, halt_sys=1, all strobes 0, ctrl_valid=0.
  - Any in-flight MC op is squashed and not retired.
  - Cause priority: DIV0 > OVF > ILLEGAL.
  - An exception in the same cycle as a valid instruction wins; that instruction is not accepted.
- EXC state:
  - exc_cause is held.
  - exc_ack=1 returns to RUN next cycle: exc_valid=0, exc_cause=00, halt_sys=0.
  - New div0/overflow while in EXC are ignored (no cause overwrite).
- retired increments on every cycle ctrl_valid=1, including HALT. It wraps from all-ones to 0.
- Reset asserted mid-MC or in EXC: immediate return to reset values.

Decomposition:
- types_pkg gains ctrl_state_e {RUN, WAIT_MC, HALTED, EXC} and exc_cause_e {EXC_NONE, EXC_DIV0, EXC_OVF, EXC_ILL}.
- types_pkg also gains a packed ctrl_bundle_t struct: alu_op, offset_sel, mem2r, memwr, reg_wr, r0_read, se_imm_a.
- alu_pkg gains the function is_multicycle(control_e).
- Sub-module control_decode: the pure combinational opcode/func to ctrl_bundle_t map, plus an illegal flag.
- control_seq owns the FSM, the MC counter, the exception latch and the retired counter.

Test Plan:
- Reset, then LW, SW, JMP on consecutive cycles:
  - ctrl_valid 1,1,1.
  - offset_sel EIGHTBIT, EIGHTBIT, TWELVEBIT; LW has mem2r=reg_wr=1.
  - retired=3.
- DIV with MC_LATENCY=4: pc_hold=1 for 3 cycles, ctrl_valid on cycle 4; a 2-cycle stall mid-op delays ctrl_valid to cycle 6.
- overflow asserted during WAIT_MC: next cycle exc_valid=1, exc_cause=10, halt_sys=1, no ctrl_valid, retired unchanged.
- div0 and overflow together with a valid ADD: exc_cause=01, ADD not retired; exc_ack returns to RUN, and the next ADD gives ctrl_valid=1.
- Undefined opcode, then HALT opcode:
  - Undefined opcode gives ILLEGAL (11); after ack, HALT gives one ctrl_valid, then halt_sys stays 1.
  - A later div0 is ignored until rst_n.
- CNT_W=4: retire 17 instructions, expect retired=1.
